// File: rtl/cache_defs.sv
// Shared definitions for the write-back data cache and its memory-side bridge:
// default line/bus geometry and the bridge FSM state encoding.
package cache_defs;

    localparam int DCACHE_LINE_WIDTH = 128;
    localparam int DMEM_BUS_WIDTH    = 32;
    localparam int DMEM_ADDR_WIDTH   = 32;

    localparam int BEATS = DCACHE_LINE_WIDTH / DMEM_BUS_WIDTH;
    localparam int OFFS  = $clog2(DCACHE_LINE_WIDTH / 8);
    localparam int BSTEP = DMEM_BUS_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } type_dmem_bridge_states_e;

endpackage

// File: rtl/wb_dcache_mem_bridge.sv
// Splits one cache-line writeback/allocate into word beats on the data-memory
// bus and returns a single-cycle line ack carrying the assembled read line.
module wb_dcache_mem_bridge
    import cache_defs::*;
#(
    parameter int LINE_WIDTH = DCACHE_LINE_WIDTH,
    parameter int BUS_WIDTH  = DMEM_BUS_WIDTH,
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dcache2mem_req_i,
    input  logic                  dcache2mem_wr_i,
    input  logic [ADDR_WIDTH-1:0] dcache2mem_addr_i,
    input  logic [LINE_WIDTH-1:0] dcache2mem_wdata_i,
    output logic                  mem2dcache_ack_o,
    output logic [LINE_WIDTH-1:0] mem2dcache_rdata_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [BUS_WIDTH-1:0]  bus_wdata_o,
    input  logic                  bus_ack_i,
    input  logic [BUS_WIDTH-1:0]  bus_rdata_i
);

    localparam int NBEATS = LINE_WIDTH / BUS_WIDTH;
    localparam int LOFFS  = $clog2(LINE_WIDTH / 8);
    localparam int LBSTEP = BUS_WIDTH / 8;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    localparam logic [CW-1:0]         LAST_BEAT = CW'(NBEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'((64'd1 << LOFFS) - 64'd1);

    type_dmem_bridge_states_e state_r;

    logic [CW-1:0]         cnt_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic                  wr_r;
    logic [LINE_WIDTH-1:0] line_buf_r;
    logic                  ack_r;
    logic [LINE_WIDTH-1:0] rdata_r;
    logic                  bus_req_r;
    logic                  bus_we_r;
    logic [ADDR_WIDTH-1:0] bus_addr_r;
    logic [BUS_WIDTH-1:0]  bus_wdata_r;

    logic [ADDR_WIDTH-1:0] base_in_s;
    logic [CW-1:0]         cnt_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_nxt_s;
    logic [BUS_WIDTH-1:0]  wdata_nxt_s;
    logic [LINE_WIDTH-1:0] line_upd_s;

    // Next-beat address/data and the line buffer with the current read beat merged in
    always_comb begin
        base_in_s   = dcache2mem_addr_i & ~OFFS_MASK;
        cnt_nxt_s   = cnt_r + CW'(1'b1);
        addr_nxt_s  = base_r + (ADDR_WIDTH'(cnt_nxt_s) * ADDR_WIDTH'(LBSTEP));
        wdata_nxt_s = line_buf_r[cnt_nxt_s*BUS_WIDTH +: BUS_WIDTH];
        line_upd_s  = line_buf_r;
        line_upd_s[cnt_r*BUS_WIDTH +: BUS_WIDTH] = bus_rdata_i;
    end

    // Bridge FSM: beat counter, line buffer and all registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            base_r      <= '0;
            wr_r        <= 1'b0;
            line_buf_r  <= '0;
            ack_r       <= 1'b0;
            rdata_r     <= '0;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= '0;
            bus_wdata_r <= '0;
        end else begin
            ack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (dcache2mem_req_i) begin
                        base_r      <= base_in_s;
                        wr_r        <= dcache2mem_wr_i;
                        cnt_r       <= '0;
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= dcache2mem_wr_i;
                        bus_addr_r  <= base_in_s;
                        state_r     <= BEAT;
                        if (dcache2mem_wr_i) begin
                            line_buf_r  <= dcache2mem_wdata_i;
                            bus_wdata_r <= dcache2mem_wdata_i[BUS_WIDTH-1:0];
                        end else begin
                            bus_wdata_r <= line_buf_r[BUS_WIDTH-1:0];
                        end
                    end
                end
                BEAT: begin
                    // A kill never withdraws a beat that the bus has not yet acked
                    if (!dcache2mem_req_i) begin
                        if (bus_ack_i) begin
                            state_r   <= IDLE;
                            bus_req_r <= 1'b0;
                            bus_we_r  <= 1'b0;
                        end else begin
                            state_r <= DRAIN;
                        end
                    end else if (bus_ack_i) begin
                        if (!wr_r) begin
                            line_buf_r <= line_upd_s;
                        end
                        if (cnt_r == LAST_BEAT) begin
                            state_r   <= DONE;
                            ack_r     <= 1'b1;
                            bus_req_r <= 1'b0;
                            bus_we_r  <= 1'b0;
                            if (!wr_r) begin
                                rdata_r <= line_upd_s;
                            end
                        end else begin
                            cnt_r       <= cnt_nxt_s;
                            bus_addr_r  <= addr_nxt_s;
                            bus_wdata_r <= wdata_nxt_s;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                DRAIN: begin
                    if (bus_ack_i) begin
                        state_r   <= IDLE;
                        bus_req_r <= 1'b0;
                        bus_we_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    bus_req_r <= 1'b0;
                    bus_we_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mem2dcache_ack_o   = ack_r;
    assign mem2dcache_rdata_o = rdata_r;
    assign bus_req_o          = bus_req_r;
    assign bus_we_o           = bus_we_r;
    assign bus_addr_o         = bus_addr_r;
    assign bus_wdata_o        = bus_wdata_r;

endmodule

// File: tb/tb_wb_dcache_mem_bridge.sv
// Scoreboard bench: stimulus pushes expected beats/acks, a monitor pops and
// compares whenever the bridge presents a bus beat or a line ack.
module tb_wb_dcache_mem_bridge;

    logic         clk;
    logic         rst_ni;
    logic         dcache2mem_req_i;
    logic         dcache2mem_wr_i;
    logic [31:0]  dcache2mem_addr_i;
    logic [127:0] dcache2mem_wdata_i;
    logic         mem2dcache_ack_o;
    logic [127:0] mem2dcache_rdata_o;
    logic         bus_req_o;
    logic         bus_we_o;
    logic [31:0]  bus_addr_o;
    logic [31:0]  bus_wdata_o;
    logic         bus_ack_i;
    logic [31:0]  bus_rdata_i;

    wb_dcache_mem_bridge dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .dcache2mem_req_i   (dcache2mem_req_i),
        .dcache2mem_wr_i    (dcache2mem_wr_i),
        .dcache2mem_addr_i  (dcache2mem_addr_i),
        .dcache2mem_wdata_i (dcache2mem_wdata_i),
        .mem2dcache_ack_o   (mem2dcache_ack_o),
        .mem2dcache_rdata_o (mem2dcache_rdata_o),
        .bus_req_o          (bus_req_o),
        .bus_we_o           (bus_we_o),
        .bus_addr_o         (bus_addr_o),
        .bus_wdata_o        (bus_wdata_o),
        .bus_ack_i          (bus_ack_i),
        .bus_rdata_i        (bus_rdata_i)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [127:0] rdata;
        int           cyc;
    } ack_t;

    beat_t beat_q[$];
    ack_t  ack_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int wait_cyc = 0;
    int wcnt     = 0;
    bit hold_ack = 1'b0;
    logic [31:0] rd_word [4];

    localparam logic [127:0] LINE_T1 = 128'h00000044_00000033_00000022_00000011;
    localparam logic [127:0] LINE_T3 = 128'h0000D4D4_0000C3C3_0000B2B2_0000A1A1;
    localparam logic [127:0] LINE_WR = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
    localparam logic [127:0] LINE_RS = 128'h70000004_70000003_70000002_70000001;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // Zero-wait or fixed-wait memory bus model; data chosen by word offset
    initial begin
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            if (!bus_req_o) begin
                bus_ack_i = 1'b0;
                wcnt = 0;
            end else if (hold_ack) begin
                bus_ack_i = 1'b0;
            end else if (wcnt >= wait_cyc) begin
                bus_ack_i = 1'b1;
                wcnt = 0;
            end else begin
                bus_ack_i = 1'b0;
                wcnt++;
            end
            bus_rdata_i = rd_word[bus_addr_o[3:2]];
        end
    end

    // Monitor: compares every presented beat and every line ack against the queues
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_ni && bus_req_o) begin
                chk("beat_expected", 128'(beat_q.size() != 0), 128'd1);
                if (beat_q.size() != 0) begin
                    chk("bus_addr", 128'(bus_addr_o), 128'(beat_q[0].addr));
                    chk("bus_we", 128'(bus_we_o), 128'(beat_q[0].we));
                    if (beat_q[0].we) begin
                        chk("bus_wdata", 128'(bus_wdata_o), 128'(beat_q[0].wdata));
                    end
                    if (bus_ack_i) begin
                        void'(beat_q.pop_front());
                    end
                end
            end
            if (mem2dcache_ack_o) begin
                chk("ack_expected", 128'(ack_q.size() != 0), 128'd1);
                if (ack_q.size() != 0) begin
                    chk("ack_rdata", mem2dcache_rdata_o, ack_q[0].rdata);
                    chk("ack_cycle", 128'(cyc), 128'(ack_q[0].cyc));
                    void'(ack_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [127:0] wdata,
                         input int nbeats, input bit exp_ack, input logic [127:0] exp_rdata);
        beat_t b;
        ack_t  a;
        logic [31:0] base;
        base = addr & 32'hFFFF_FFF0;
        for (int i = 0; i < nbeats; i++) begin
            b.addr  = base + 32'(i * 4);
            b.we    = wr;
            b.wdata = wdata[i*32 +: 32];
            beat_q.push_back(b);
        end
        if (exp_ack) begin
            a.rdata = exp_rdata;
            a.cyc   = cyc + 1 + 4 * (wait_cyc + 1);
            ack_q.push_back(a);
        end
        dcache2mem_req_i   = 1'b1;
        dcache2mem_wr_i    = wr;
        dcache2mem_addr_i  = addr;
        dcache2mem_wdata_i = wdata;
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!mem2dcache_ack_o && n < 100);
        chk("ack_seen", 128'(mem2dcache_ack_o), 128'd1);
        dcache2mem_req_i = 1'b0;
    endtask

    initial begin
        rst_ni             = 1'b0;
        dcache2mem_req_i   = 1'b0;
        dcache2mem_wr_i    = 1'b0;
        dcache2mem_addr_i  = 32'h0;
        dcache2mem_wdata_i = 128'h0;
        rd_word[0] = 32'h11; rd_word[1] = 32'h22; rd_word[2] = 32'h33; rd_word[3] = 32'h44;
        repeat (3) step();
        rst_ni = 1'b1;
        step();
        chk("rst_bus_req", 128'(bus_req_o), 128'd0);
        chk("rst_bus_we", 128'(bus_we_o), 128'd0);
        chk("rst_bus_addr", 128'(bus_addr_o), 128'd0);
        chk("rst_bus_wdata", 128'(bus_wdata_o), 128'd0);
        chk("rst_ack", 128'(mem2dcache_ack_o), 128'd0);
        chk("rst_rdata", mem2dcache_rdata_o, 128'd0);

        // Allocate, zero-wait bus
        issue(1'b0, 32'h8000_1234, 128'h0, 4, 1'b1, LINE_T1);
        wait_ack();

        // Writeback with two wait cycles per beat; rdata_o keeps the last allocate
        step();
        wait_cyc = 2;
        issue(1'b1, 32'h0000_2048, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 4, 1'b1, LINE_T1);
        wait_ack();
        wait_cyc = 0;

        // Writeback immediately followed by allocate
        step();
        issue(1'b1, 32'h0000_0100, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 4, 1'b1, LINE_T1);
        wait_ack();
        rd_word[0] = 32'hA1A1; rd_word[1] = 32'hB2B2; rd_word[2] = 32'hC3C3; rd_word[3] = 32'hD4D4;
        step();
        issue(1'b0, 32'h0000_0200, 128'h0, 4, 1'b1, LINE_T3);
        wait_ack();

        // Kill in the second beat with the bus stalled: drain, then idle
        step();
        issue(1'b0, 32'h0000_3000, 128'h0, 2, 1'b0, 128'h0);
        step();
        hold_ack = 1'b1;
        step();
        dcache2mem_req_i = 1'b0;
        step();
        chk("drain_req_held", 128'(bus_req_o), 128'd1);
        chk("drain_addr_held", 128'(bus_addr_o), 128'h3004);
        step();
        chk("drain_req_held2", 128'(bus_req_o), 128'd1);
        hold_ack = 1'b0;
        step();
        step();
        chk("drain_req_released", 128'(bus_req_o), 128'd0);
        chk("drain_rdata_kept", mem2dcache_rdata_o, LINE_T3);

        // Kill on the same cycle as the last-beat bus ack
        issue(1'b0, 32'h0000_4000, 128'h0, 4, 1'b0, 128'h0);
        repeat (4) step();
        dcache2mem_req_i = 1'b0;
        step();
        chk("kill_last_req", 128'(bus_req_o), 128'd0);
        chk("kill_last_ack", 128'(mem2dcache_ack_o), 128'd0);
        step();

        // Line at the top of the address space
        rd_word[0] = 32'hCAFE0000; rd_word[1] = 32'hCAFE0001;
        rd_word[2] = 32'hCAFE0002; rd_word[3] = 32'hCAFE0003;
        issue(1'b0, 32'hFFFF_FFF0, 128'h0, 4, 1'b1, LINE_WR);
        wait_ack();

        // Asynchronous reset in the middle of a beat
        step();
        issue(1'b0, 32'h0000_6000, 128'h0, 2, 1'b0, 128'h0);
        step();
        step();
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst_bus_req", 128'(bus_req_o), 128'd0);
        chk("arst_bus_addr", 128'(bus_addr_o), 128'd0);
        chk("arst_ack", 128'(mem2dcache_ack_o), 128'd0);
        chk("arst_rdata", mem2dcache_rdata_o, 128'd0);
        dcache2mem_req_i = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
        rd_word[0] = 32'h70000001; rd_word[1] = 32'h70000002;
        rd_word[2] = 32'h70000003; rd_word[3] = 32'h70000004;
        issue(1'b0, 32'h0000_7000, 128'h0, 4, 1'b1, LINE_RS);
        wait_ack();

        repeat (4) step();
        chk("beat_q_empty", 128'(beat_q.size()), 128'd0);
        chk("ack_q_empty", 128'(ack_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_dcache_mem_bridge.md
Name: wb_dcache_mem_bridge

Overview:
- Sits directly downstream of the write-back data cache controller/datapath, between the cache and the data-memory bus.
- Converts one cache-line transaction (line writeback or line allocate) into a sequence of word-wide beats on a narrower memory bus.
- Returns a single-cycle line-level ack (mem2dcache_ack_o) once all beats complete, with the assembled read line.

Parameters:
- LINE_WIDTH, 128, cache line width in bits.
- BUS_WIDTH, 32, memory bus data width in bits; LINE_WIDTH must be an integer multiple.
- ADDR_WIDTH, 32, byte address width.
- Derived constants:
  - BEATS = LINE_WIDTH/BUS_WIDTH (default 4).
  - OFFS = log2(LINE_WIDTH/8) line-offset bits.
  - BSTEP = BUS_WIDTH/8 bytes per beat.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- dcache2mem_req_i  in  1  line request; level, held by the cache until ack or kill.
- dcache2mem_wr_i  in  1  1 = writeback line, 0 = allocate (read) line.
- dcache2mem_addr_i  in  ADDR_WIDTH  line byte address; low OFFS bits ignored.
- dcache2mem_wdata_i  in  LINE_WIDTH  line to write back.
- mem2dcache_ack_o  out  1  one-cycle completion pulse.
- mem2dcache_rdata_o  out  LINE_WIDTH  assembled allocate line.
- bus_req_o  out  1  beat request.
- bus_we_o  out  1  beat write enable.
- bus_addr_o  out  ADDR_WIDTH  beat byte address.
- bus_wdata_o  out  BUS_WIDTH  beat write data.
- bus_ack_i  in  1  beat accepted/completed; read data is valid in the same cycle.
- bus_rdata_i  in  BUS_WIDTH  beat read data.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, beat counter = 0.
  - All outputs 0, including rdata_o and the line buffer.
- States:
  - IDLE: accept a request.
  - BEAT: issue beats.
  - DONE: pulse ack.
  - DRAIN: finish an abandoned beat.
- IDLE:
  - On dcache2mem_req_i = 1, latch address (low OFFS bits forced to 0), the wr flag and, for writes, dcache2mem_wdata_i into the line buffer.
  - Clear the counter and go to BEAT.
  - No bus activity in the accept cycle.
- BEAT:
  - bus_req_o = 1.
  - bus_we_o = latched wr.
  - bus_addr_o = base + cnt*BSTEP.
  - bus_wdata_o = line_buf[cnt*BUS_WIDTH +: BUS_WIDTH].
  - Address, we and wdata are stable until bus_ack_i.
  - On bus_ack_i, for reads, write bus_rdata_i into line_buf slice cnt; beat 0 is the least-significant word.
  - If cnt == BEATS-1, go to DONE; else cnt+1 and stay in BEAT.
  - bus_req_o stays high back-to-back between beats.
- DONE:
  - mem2dcache_ack_o = 1 for exactly one cycle, bus_req_o = 0.
  - mem2dcache_rdata_o is driven from line_buf and stays valid until the next allocate starts.
  - dcache2mem_req_i is ignored in this cycle (the controller drops req in the ack cycle). Next state is IDLE.
- Latency, zero-wait bus (bus_ack_i tied high while requested):
  - Request seen in cycle N.
  - Bus beats occur in N+1..N+BEATS.
  - Ack in N+BEATS+1.
  - Every bus wait cycle adds one.
- Back-to-back transactions: a writeback followed by an allocate re-enters IDLE and needs a new accept cycle. Minimum gap between two acks = BEATS+2 cycles.
- Kill: dcache2mem_req_i = 0 in BEAT is an abort; no mem2dcache_ack_o is ever issued for an aborted transaction.
  - If bus_ack_i is also 1 that cycle, go to IDLE.
  - Else go to DRAIN. A bus beat must never be withdrawn before its ack.
- DRAIN:
  - Hold bus_req_o and the current beat signals until bus_ack_i, then IDLE.
  - Read data captured here does not update rdata_o.
  - New requests are ignored until IDLE.
- Address wrap: base + cnt*BSTEP is computed modulo 2^ADDR_WIDTH; no carry out.
- bus_ack_i is ignored whenever bus_req_o = 0.
- Reset asserted mid-transaction aborts immediately: bus_req_o drops asynchronously, with no ack.

Decomposition:
- cache_defs package:
  - type_dmem_bridge_states_e (IDLE, BEAT, DONE, DRAIN).
  - DCACHE_LINE_WIDTH, DMEM_BUS_WIDTH and derived BEATS/OFFS constants.
- No sub-module; the FSM, counter and line buffer stay in one file.

Test Plan:
- Allocate, addr 0x8000_1234, zero-wait bus -> bus_addr_o 0x8000_1230, 0x..34, 0x..38, 0x..3C on consecutive cycles. Rdata words 0x11,0x22,0x33,0x44 give rdata_o = 0x00000044_00000033_00000022_00000011. Ack exactly at N+5, one cycle.
- Writeback, wdata 0xDDDD_CCCC_BBBB_AAAA_... with bus_ack_i delayed 2 cycles per beat -> bus_wdata_o word order 0th..3rd slice, each held stable through waits, we = 1. Ack at N+1+4*3.
- Writeback followed immediately by allocate (controller-style req levels) -> two separate beat sequences. Acks separated by ≥6 cycles; rdata_o unchanged by the writeback.
- Req dropped in the 2nd beat with bus_ack_i low -> bus_req_o held until ack (DRAIN), then 0. No mem2dcache_ack_o; next request accepted normally.
- Req dropped in the same cycle as the last-beat bus_ack_i -> IDLE next cycle, no ack.
- rst_ni pulsed low mid-beat (asynchronously, between edges) -> all outputs 0 immediately. A fresh allocate after release completes correctly.
- Line address 0xFFFF_FFF0 -> beats at 0x..F0, 0x..F4, 0x..F8, 0x..FC, with no carry out of ADDR_WIDTH.
